// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cache-side and memory-side burst transaction interfaces
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     mem_valid_i;
    logic                     mem_read_write_i;
    logic [ADDRESS_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0]    mem_data_i;
    logic                     mem_valid_o;
    logic                     mem_data_read_o;
    logic                     mem_last_o;
    logic [DATA_WIDTH-1:0]    mem_data_o;

    modport master (
        output mem_valid_i, mem_read_write_i, mem_addr_i, mem_data_i,
        input  mem_valid_o, mem_data_read_o, mem_last_o, mem_data_o
    );
    modport slave (
        input  mem_valid_i, mem_read_write_i, mem_addr_i, mem_data_i,
        output mem_valid_o, mem_data_read_o, mem_last_o, mem_data_o
    );
endinterface

interface mem_bus_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     mem_valid_o;
    logic                     mem_read_write_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0]    mem_data_o;
    logic                     mem_valid_i;
    logic                     mem_data_read_i;
    logic                     mem_last_i;
    logic [DATA_WIDTH-1:0]    mem_data_i;

    modport master (
        output mem_valid_o, mem_read_write_o, mem_addr_o, mem_data_o,
        input  mem_valid_i, mem_data_read_i, mem_last_i, mem_data_i
    );
    modport slave (
        input  mem_valid_o, mem_read_write_o, mem_addr_o, mem_data_o,
        output mem_valid_i, mem_data_read_i, mem_last_i, mem_data_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin burst arbiter sharing one memory port between two caches
module mem_port_arbiter #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 32,
    parameter int BLOCK_OFFSET_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_port_arbiter_if.slave       p0,
    mem_port_arbiter_if.slave       p1,
    mem_bus_if.master               mem,
    output logic [1:0]              grant_o,
    output logic                    err_o
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [BLOCK_OFFSET_WIDTH-1:0] CNT_MAX = '1;

    state_t                        state, state_next;
    logic                          last_grant, last_grant_next;
    logic [ADDRESS_WIDTH-1:0]      addr_q, addr_next;
    logic                          rw_q, rw_next;
    logic [BLOCK_OFFSET_WIDTH-1:0] cnt, cnt_next;
    logic                          err_next;

    logic own0, own1, busy, beat, owner_valid;

    assign own0        = (state == GRANT0);
    assign own1        = (state == GRANT1);
    assign busy        = own0 | own1;
    assign beat        = mem.mem_valid_i | mem.mem_data_read_i;
    assign owner_valid = (own0 & p0.mem_valid_i) | (own1 & p1.mem_valid_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            cnt        <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            addr_q     <= addr_next;
            rw_q       <= rw_next;
            cnt        <= cnt_next;
            err_o      <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        addr_next       = addr_q;
        rw_next         = rw_q;
        cnt_next        = cnt;
        err_next        = err_o;
        case (state)
            IDLE: begin
                // any memory strobe with no owner is a protocol error and is otherwise dropped
                if (beat || mem.mem_last_i) err_next = 1'b1;
                if (p0.mem_valid_i && (!p1.mem_valid_i || last_grant)) begin
                    state_next      = GRANT0;
                    addr_next       = p0.mem_addr_i;
                    rw_next         = p0.mem_read_write_i;
                    last_grant_next = 1'b0;
                    cnt_next        = '0;
                end else if (p1.mem_valid_i) begin
                    state_next      = GRANT1;
                    addr_next       = p1.mem_addr_i;
                    rw_next         = p1.mem_read_write_i;
                    last_grant_next = 1'b1;
                    cnt_next        = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (beat) begin
                    cnt_next = cnt + 1'b1;
                    if (mem.mem_last_i) begin
                        state_next = IDLE;
                        if (cnt != CNT_MAX) err_next = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        // overrun past a full line: counter wraps, ownership is kept
                        err_next = 1'b1;
                    end
                end
                if (!owner_valid && !(beat && mem.mem_last_i)) err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_o = {own1, own0};

    assign mem.mem_valid_o      = busy;
    assign mem.mem_read_write_o = busy & rw_q;
    assign mem.mem_addr_o       = busy ? addr_q : '0;
    assign mem.mem_data_o       = own0 ? p0.mem_data_i : (own1 ? p1.mem_data_i : '0);

    assign p0.mem_valid_o     = own0 & mem.mem_valid_i;
    assign p0.mem_data_read_o = own0 & mem.mem_data_read_i;
    assign p0.mem_last_o      = own0 & mem.mem_last_i;
    assign p0.mem_data_o      = own0 ? mem.mem_data_i : '0;

    assign p1.mem_valid_o     = own1 & mem.mem_valid_i;
    assign p1.mem_data_read_o = own1 & mem.mem_data_read_i;
    assign p1.mem_last_o      = own1 & mem.mem_last_i;
    assign p1.mem_data_o      = own1 ? mem.mem_data_i : '0;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single burst memory port between the instruction cache (port 0) and the data cache (port 1). It sits between the caches' `mem_*` transaction interfaces and main memory. It grants one whole cache-line burst at a time, round-robin, and latches the command for the duration of the burst. It routes per-beat data and handshakes back to the granted cache only, and flags protocol violations.

## Interface
- `DATA_WIDTH`, 32, beat width.
- `ADDRESS_WIDTH`, 32, address width.
- `BLOCK_OFFSET_WIDTH`, 2, log2 beats per burst (4 beats).
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `p0_mem_valid_i`, `p1_mem_valid_i` in 1: burst request; held high until the port sees its `last_o`.
- `p0_mem_read_write_i`, `p1_mem_read_write_i` in 1: 1 = read, 0 = write.
- `p0_mem_addr_i`, `p1_mem_addr_i` in ADDRESS_WIDTH: burst start address.
- `p0_mem_data_i`, `p1_mem_data_i` in DATA_WIDTH: current write beat.
- `p0_mem_valid_o`, `p1_mem_valid_o` out 1: read beat valid for this port.
- `p0_mem_data_read_o`, `p1_mem_data_read_o` out 1: write beat consumed for this port.
- `p0_mem_last_o`, `p1_mem_last_o` out 1: final beat of this port's burst.
- `p0_mem_data_o`, `p1_mem_data_o` out DATA_WIDTH: read beat data.
- `mem_valid_o` out 1: transaction active toward memory.
- `mem_read_write_o` out 1: latched direction.
- `mem_addr_o` out ADDRESS_WIDTH: latched address.
- `mem_data_o` out DATA_WIDTH: write beat, taken from the granted port.
- `mem_valid_i`, `mem_data_read_i`, `mem_last_i` in 1: memory beat handshakes.
- `mem_data_i` in DATA_WIDTH: memory read data.
- `grant_o` out 2: one-hot current owner; 00 when idle.
- `err_o` out 1: sticky protocol error.

## Operation
- States:
  - IDLE: no owner.
  - GRANT0: port 0 owns memory.
  - GRANT1: port 1 owns memory.
- IDLE selection:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to `last_grant` is granted.
  - On grant, latch the port's addr and rw, update `last_grant`, clear the beat counter.
- `last_grant` resets to 1, so port 0 wins the first tie.
- GRANTx:
  - `mem_valid_o` = 1; addr and rw come from the latches.
  - `mem_data_o` = `px_mem_data_i`, combinational.
  - `mem_valid_i`, `mem_data_read_i`, `mem_last_i` are forwarded, each gated by ownership. Memory read data goes to `px_mem_data_o`.
  - The non-owner sees all response strobes at 0.
- A beat is `mem_valid_i` (read) or `mem_data_read_i` (write). The beat counter is BLOCK_OFFSET_WIDTH bits and increments on each beat.
- On a beat with `mem_last_i` = 1, return to IDLE.
- `err_o` is set (sticky until reset) when:
  - `mem_last_i` arrives with counter ≠ 2^BLOCK_OFFSET_WIDTH−1;
  - the owner drops `mem_valid_i` before its last beat — the burst still runs to `mem_last_i`, with write beats taken as-is;
  - a response strobe arrives in IDLE — the strobe is ignored.
- Counter wrap beyond the final beat (no `mem_last_i`): counter wraps, `err_o` is set, grant is held.

## Timing
- Reset (async assert): state IDLE, `grant_o` = 00, all outputs 0, `last_grant` = 1, `err_o` = 0, latches 0. Reset mid-burst abandons the burst; memory is reset by the same signal.
- Grant latency: request sampled high in IDLE at cycle N → `grant_o` and `mem_valid_o` high in cycle N+1.
- Response path is combinational (zero latency) from `mem_*_i` to `px_*_o`.
- Last beat in cycle M → `mem_valid_o` = 0 and `grant_o` = 00 in M+1.
  - M+1 is a mandatory IDLE cycle; the earliest next `mem_valid_o` is M+2.
  - A requester must drop its valid in M+1 unless it wants a new burst.
- Back-to-back with both ports requesting: ownership alternates strictly.
- Requests arriving during GRANTx wait with no timeout.

## Test plan
- Single read, port 0, addr 0x100, 4 beats 0xA0..0xA3 → grant 01 one cycle after request; `p0_mem_data_o` carries 0xA0..0xA3 with `p0_mem_valid_o`; `p0_mem_last_o` on the 4th beat; IDLE the next cycle; `p1_*` strobes stay 0.
- Simultaneous requests after reset (p0 read 0x200, p1 write 0x300) → port 0 granted first, port 1 granted at M+2. Memory sees addr 0x300, rw 0, and p1's write beats on `mem_data_o` paced by `mem_data_read_i`.
- Both ports requesting continuously for 4 bursts → grants 01, 10, 01, 10; one idle cycle between bursts; `err_o` = 0.
- `mem_last_i` on the 2nd beat → burst ends, `err_o` = 1 and stays 1 through later clean bursts.
- Port 1 changes `p1_mem_addr_i` and drops its valid mid-burst → `mem_addr_o` unchanged, burst completes, `err_o` = 1.
- `rst` asserted low mid-burst (asynchronously, between edges) → all outputs 0 immediately. After release, an identical tie grants port 0 first.
